// File: rtl/uart_pkg.sv
// Shared definitions for the UART echo responder: byte width, stats width,
// echo FSM state encoding and a saturating increment helper.
package uart_pkg;

   localparam int unsigned UART_BYTE_W = 8;
   localparam int unsigned UART_STAT_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } echo_state_t;

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [UART_STAT_W-1:0] sat_inc(input logic [UART_STAT_W-1:0] value);
      return (value == '1) ? value : value + UART_STAT_W'(1);
   endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Circular byte FIFO with registered occupancy. Pointers wrap naturally;
// the occupancy counter is one bit wider so full and empty are distinct.
module uart_byte_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic [UART_BYTE_W-1:0] wr_data,
   output logic [UART_BYTE_W-1:0] rd_data_c,
   output logic                   full_c,
   output logic                   empty_c,
   output logic [$clog2(DEPTH):0] level
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [UART_BYTE_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]       wr_ptr;
   logic [PTR_W-1:0]       rd_ptr;
   logic                   wr_en_c;
   logic                   rd_en_c;

   assign full_c    = (level == (PTR_W+1)'(DEPTH));
   assign empty_c   = (level == '0);
   assign rd_en_c   = pop && !empty_c;
   // A push into a full buffer is only safe when the head leaves in the same cycle
   assign wr_en_c   = push && (!full_c || rd_en_c);
   assign rd_data_c = mem[rd_ptr];

   // Storage array; contents need no reset since level gates every read
   always_ff @(posedge clk) begin
      if (wr_en_c) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers and occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_en_c) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (rd_en_c) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         unique case ({wr_en_c, rd_en_c})
            2'b10:   level <= level + (PTR_W+1)'(1);
            2'b01:   level <= level - (PTR_W+1)'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/uart_echo_responder.sv
// Device-side UART echo responder: buffers received bytes and replays each
// one (XORed with ECHO_XOR) to the transmitter, with an optional idle gap.
// Optional feature macro: UART_ECHO_STATS_EN adds saturating rx/tx counters.
module uart_echo_responder
   import uart_pkg::*;
#(
   parameter int unsigned            DEPTH      = 8,
   parameter logic [UART_BYTE_W-1:0] ECHO_XOR   = 8'h00,
   parameter logic [15:0]            GAP_CYCLES = 16'd0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_Rx_Done,
   input  logic [UART_BYTE_W-1:0] i_Rx_Byte,
   input  logic                   i_Tx_Done,
   output logic                   o_Tx_Ready,
   output logic [UART_BYTE_W-1:0] o_Tx_Byte,
   output logic                   o_Busy,
   output logic [$clog2(DEPTH):0] o_Level,
   output logic                   o_Overrun,
   input  logic                   i_Clr_Overrun
`ifdef UART_ECHO_STATS_EN
   ,
   output logic [UART_STAT_W-1:0] o_Rx_Count,
   output logic [UART_STAT_W-1:0] o_Tx_Count
`endif
);

   echo_state_t            state;
   logic [15:0]            gap_cnt;
   logic [UART_BYTE_W-1:0] fifo_head_c;
   logic                   fifo_full_c;
   logic                   fifo_empty_c;
   logic                   pop_c;
   logic                   accept_c;
   logic                   drop_c;

   assign pop_c    = (state == ST_IDLE) && !fifo_empty_c;
   assign accept_c = i_Rx_Done && (!fifo_full_c || pop_c);
   assign drop_c   = i_Rx_Done && fifo_full_c && !pop_c;

   uart_byte_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (i_Rx_Done),
      .pop       (pop_c),
      .wr_data   (i_Rx_Byte),
      .rd_data_c (fifo_head_c),
      .full_c    (fifo_full_c),
      .empty_c   (fifo_empty_c),
      .level     (o_Level)
   );

   // Echo FSM: launch one byte, wait for the transmitter, then optional idle gap
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         gap_cnt    <= '0;
         o_Tx_Ready <= 1'b0;
         o_Tx_Byte  <= '0;
         o_Busy     <= 1'b0;
      end else begin
         o_Tx_Ready <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (pop_c) begin
                  o_Tx_Byte  <= fifo_head_c ^ ECHO_XOR;
                  o_Tx_Ready <= 1'b1;
                  o_Busy     <= 1'b1;
                  state      <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (i_Tx_Done) begin
                  if (GAP_CYCLES != 16'd0) begin
                     // Counter spans GAP_CYCLES idle clocks including the exit cycle
                     gap_cnt <= GAP_CYCLES - 16'd1;
                     state   <= ST_GAP;
                  end else begin
                     o_Busy <= 1'b0;
                     state  <= ST_IDLE;
                  end
               end
            end
            ST_GAP: begin
               if (gap_cnt == 16'd0) begin
                  o_Busy <= 1'b0;
                  state  <= ST_IDLE;
               end else begin
                  gap_cnt <= gap_cnt - 16'd1;
               end
            end
            default: begin
               o_Busy <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

   // Sticky overrun flag; a fresh drop beats a simultaneous clear
   always_ff @(posedge clk) begin
      if (reset) begin
         o_Overrun <= 1'b0;
      end else if (drop_c) begin
         o_Overrun <= 1'b1;
      end else if (i_Clr_Overrun) begin
         o_Overrun <= 1'b0;
      end
   end

`ifdef UART_ECHO_STATS_EN
   // Saturating counts of accepted bytes and launched echoes
   always_ff @(posedge clk) begin
      if (reset) begin
         o_Rx_Count <= '0;
         o_Tx_Count <= '0;
      end else begin
         if (accept_c) begin
            o_Rx_Count <= sat_inc(o_Rx_Count);
         end
         if (pop_c) begin
            o_Tx_Count <= sat_inc(o_Tx_Count);
         end
      end
   end
`else
   // Acceptance only feeds the counters; keep it referenced when they are absent
   logic unused_accept_c;
   assign unused_accept_c = accept_c;
`endif

endmodule

// File: tb/tb_uart_echo_responder.sv
// Directed testbench for uart_echo_responder (DEPTH=8, ECHO_XOR=FF, GAP_CYCLES=5).
module tb_uart_echo_responder;
   import uart_pkg::*;

   localparam int unsigned DEPTH      = 8;
   localparam logic [7:0]  ECHO_XOR   = 8'hFF;
   localparam logic [15:0] GAP_CYCLES = 16'd5;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       i_Rx_Done = 1'b0;
   logic [7:0] i_Rx_Byte = 8'h00;
   logic       i_Tx_Done = 1'b0;
   logic       i_Clr_Overrun = 1'b0;
   logic       o_Tx_Ready;
   logic [7:0] o_Tx_Byte;
   logic       o_Busy;
   logic [3:0] o_Level;
   logic       o_Overrun;
`ifdef UART_ECHO_STATS_EN
   logic [15:0] o_Rx_Count;
   logic [15:0] o_Tx_Count;
`endif

   int vectors = 0;
   int miscompares = 0;

   uart_echo_responder #(
      .DEPTH      (DEPTH),
      .ECHO_XOR   (ECHO_XOR),
      .GAP_CYCLES (GAP_CYCLES)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .i_Rx_Done     (i_Rx_Done),
      .i_Rx_Byte     (i_Rx_Byte),
      .i_Tx_Done     (i_Tx_Done),
      .o_Tx_Ready    (o_Tx_Ready),
      .o_Tx_Byte     (o_Tx_Byte),
      .o_Busy        (o_Busy),
      .o_Level       (o_Level),
      .o_Overrun     (o_Overrun),
      .i_Clr_Overrun (i_Clr_Overrun)
`ifdef UART_ECHO_STATS_EN
      ,
      .o_Rx_Count    (o_Rx_Count),
      .o_Tx_Count    (o_Tx_Count)
`endif
   );

   always #5 clk = ~clk;

   // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Bounded wait for a start pulse; reports how many clocks it took
   task automatic wait_ready(input int max_cycles, output int waited, output bit seen);
      seen   = 1'b0;
      waited = 0;
      for (int i = 0; i < max_cycles && !seen; i++) begin
         tick();
         waited = i + 1;
         if (o_Tx_Ready === 1'b1) seen = 1'b1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      vectors++;
      if ({o_Tx_Ready, o_Tx_Byte, o_Busy, o_Level, o_Overrun} !== 15'h0) begin
         miscompares++;
         $display("FAIL reset_outputs: got rdy=%b byte=%h busy=%b lvl=%0d ovr=%b want all zero",
                  o_Tx_Ready, o_Tx_Byte, o_Busy, o_Level, o_Overrun);
      end
`ifdef UART_ECHO_STATS_EN
      vectors++;
      if ({o_Rx_Count, o_Tx_Count} !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_counts: got rx=%0d tx=%0d want 0 0", o_Rx_Count, o_Tx_Count);
      end
`endif
   endtask

   task automatic test_single_echo();
      i_Rx_Done = 1'b1; i_Rx_Byte = 8'h55;
      tick();
      i_Rx_Done = 1'b0;
      vectors++;
      if ({o_Level, o_Tx_Ready} !== {4'd1, 1'b0}) begin
         miscompares++;
         $display("FAIL single_n1: got lvl=%0d rdy=%b want lvl=1 rdy=0", o_Level, o_Tx_Ready);
      end
      tick();
      vectors++;
      if ({o_Tx_Ready, o_Tx_Byte, o_Busy} !== {1'b1, 8'hAA, 1'b1}) begin
         miscompares++;
         $display("FAIL single_n2: got rdy=%b byte=%h busy=%b want 1 aa 1", o_Tx_Ready, o_Tx_Byte, o_Busy);
      end
      tick();
      vectors++;
      if ({o_Tx_Ready, o_Busy, o_Level} !== {1'b0, 1'b1, 4'd0}) begin
         miscompares++;
         $display("FAIL single_pulse_width: got rdy=%b busy=%b lvl=%0d want 0 1 0", o_Tx_Ready, o_Busy, o_Level);
      end
      repeat (4) tick();
      vectors++;
      if ({o_Busy, o_Tx_Byte} !== {1'b1, 8'hAA}) begin
         miscompares++;
         $display("FAIL single_hold: got busy=%b byte=%h want 1 aa", o_Busy, o_Tx_Byte);
      end
      i_Tx_Done = 1'b1;
      tick();
      i_Tx_Done = 1'b0;
      repeat (4) tick();
      vectors++;
      if (o_Busy !== 1'b1) begin
         miscompares++;
         $display("FAIL gap_m5_busy: got %b want 1", o_Busy);
      end
      tick();
      vectors++;
      if (o_Busy !== 1'b0) begin
         miscompares++;
         $display("FAIL gap_m6_idle: got %b want 0", o_Busy);
      end
   endtask

   task automatic test_xor_order();
      logic [7:0] exp_bytes [2];
      int  waited;
      bit  seen;
      exp_bytes[0] = 8'hEF;
      exp_bytes[1] = 8'h55;
      i_Rx_Done = 1'b1; i_Rx_Byte = 8'h01;
      tick();
      i_Rx_Byte = 8'h10;
      tick();
      i_Rx_Byte = 8'hAA;
      vectors++;
      if ({o_Tx_Ready, o_Tx_Byte} !== {1'b1, 8'hFE}) begin
         miscompares++;
         $display("FAIL xor_first: got rdy=%b byte=%h want 1 fe", o_Tx_Ready, o_Tx_Byte);
      end
      tick();
      i_Rx_Done = 1'b0;
      vectors++;
      if (o_Level !== 4'd2) begin
         miscompares++;
         $display("FAIL xor_peak_level: got %0d want 2", o_Level);
      end
      for (int k = 0; k < 2; k++) begin
         repeat (2) tick();
         i_Tx_Done = 1'b1;
         tick();
         i_Tx_Done = 1'b0;
         wait_ready(20, waited, seen);
         vectors++;
         if (!seen || (waited + 1) != 7 || o_Tx_Byte !== exp_bytes[k]) begin
            miscompares++;
            $display("FAIL xor_b2b_%0d: got seen=%b latency=%0d byte=%h want 1 7 %h",
                     k, seen, waited + 1, o_Tx_Byte, exp_bytes[k]);
         end
      end
      i_Tx_Done = 1'b1;
      tick();
      i_Tx_Done = 1'b0;
      repeat (8) tick();
      vectors++;
      if ({o_Busy, o_Level} !== {1'b0, 4'd0}) begin
         miscompares++;
         $display("FAIL xor_drain: got busy=%b lvl=%0d want 0 0", o_Busy, o_Level);
      end
   endtask

   task automatic test_overrun();
      for (int i = 0; i < 10; i++) begin
         i_Rx_Done = 1'b1;
         i_Rx_Byte = 8'h10 + 8'(i);
         tick();
         if (i == 8) begin
            vectors++;
            if ({o_Level, o_Overrun} !== {4'd8, 1'b0}) begin
               miscompares++;
               $display("FAIL ovr_full_no_flag: got lvl=%0d ovr=%b want 8 0", o_Level, o_Overrun);
            end
         end
      end
      i_Rx_Done = 1'b0;
      vectors++;
      if ({o_Level, o_Overrun, o_Tx_Byte} !== {4'd8, 1'b1, 8'hEF}) begin
         miscompares++;
         $display("FAIL ovr_set: got lvl=%0d ovr=%b byte=%h want 8 1 ef", o_Level, o_Overrun, o_Tx_Byte);
      end
      i_Rx_Done = 1'b1; i_Rx_Byte = 8'h99; i_Clr_Overrun = 1'b1;
      tick();
      i_Rx_Done = 1'b0; i_Clr_Overrun = 1'b0;
      vectors++;
      if ({o_Level, o_Overrun} !== {4'd8, 1'b1}) begin
         miscompares++;
         $display("FAIL ovr_set_wins: got lvl=%0d ovr=%b want 8 1", o_Level, o_Overrun);
      end
      i_Clr_Overrun = 1'b1;
      tick();
      i_Clr_Overrun = 1'b0;
      vectors++;
      if (o_Overrun !== 1'b0) begin
         miscompares++;
         $display("FAIL ovr_clear: got %b want 0", o_Overrun);
      end
   endtask

   task automatic test_full_push_pop();
      i_Tx_Done = 1'b1;
      tick();
      i_Tx_Done = 1'b0;
      repeat (5) tick();
      vectors++;
      if ({o_Busy, o_Level} !== {1'b0, 4'd8}) begin
         miscompares++;
         $display("FAIL full_idle: got busy=%b lvl=%0d want 0 8", o_Busy, o_Level);
      end
      i_Rx_Done = 1'b1; i_Rx_Byte = 8'h5A;
      tick();
      i_Rx_Done = 1'b0;
      vectors++;
      if ({o_Tx_Ready, o_Tx_Byte, o_Level, o_Overrun} !== {1'b1, 8'hEE, 4'd8, 1'b0}) begin
         miscompares++;
         $display("FAIL full_push_pop: got rdy=%b byte=%h lvl=%0d ovr=%b want 1 ee 8 0",
                  o_Tx_Ready, o_Tx_Byte, o_Level, o_Overrun);
      end
   endtask

   task automatic test_reset_mid_send();
      bit seen_ready;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      vectors++;
      if ({o_Tx_Ready, o_Tx_Byte, o_Busy, o_Level, o_Overrun} !== 15'h0) begin
         miscompares++;
         $display("FAIL midreset_outputs: got rdy=%b byte=%h busy=%b lvl=%0d ovr=%b want all zero",
                  o_Tx_Ready, o_Tx_Byte, o_Busy, o_Level, o_Overrun);
      end
      seen_ready = 1'b0;
      i_Tx_Done = 1'b1;
      tick();
      i_Tx_Done = 1'b0;
      if (o_Tx_Ready === 1'b1) seen_ready = 1'b1;
      repeat (12) begin
         tick();
         if (o_Tx_Ready === 1'b1) seen_ready = 1'b1;
      end
      vectors++;
      if ({seen_ready, o_Busy, o_Level} !== {1'b0, 1'b0, 4'd0}) begin
         miscompares++;
         $display("FAIL midreset_stray_done: got pulse=%b busy=%b lvl=%0d want 0 0 0",
                  seen_ready, o_Busy, o_Level);
      end
   endtask

   task automatic test_loopback();
      logic [7:0] host [8];
      int  waited;
      bit  seen;
      host[0] = 8'h21; host[1] = 8'h11; host[2] = 8'h32; host[3] = 8'h77;
      host[4] = 8'hA0; host[5] = 8'h0B; host[6] = 8'hBB; host[7] = 8'hFF;
      i_Rx_Done = 1'b1; i_Rx_Byte = host[0];
      tick();
      i_Rx_Done = 1'b0;
      wait_ready(10, waited, seen);
      vectors++;
      if (!seen || waited != 1 || o_Tx_Byte !== (host[0] ^ 8'hFF)) begin
         miscompares++;
         $display("FAIL loop_byte0: got seen=%b wait=%0d byte=%h want 1 1 %h",
                  seen, waited, o_Tx_Byte, host[0] ^ 8'hFF);
      end
      for (int i = 1; i < 8; i++) begin
         i_Rx_Done = 1'b1;
         i_Rx_Byte = host[i];
         tick();
      end
      i_Rx_Done = 1'b0;
      for (int k = 1; k < 8; k++) begin
         repeat (3) tick();
         i_Tx_Done = 1'b1;
         tick();
         i_Tx_Done = 1'b0;
         wait_ready(20, waited, seen);
         vectors++;
         if (!seen || (waited + 1) != 7 || o_Tx_Byte !== (host[k] ^ 8'hFF)) begin
            miscompares++;
            $display("FAIL loop_byte%0d: got seen=%b latency=%0d byte=%h want 1 7 %h",
                     k, seen, waited + 1, o_Tx_Byte, host[k] ^ 8'hFF);
         end
      end
      i_Tx_Done = 1'b1;
      tick();
      i_Tx_Done = 1'b0;
      repeat (8) tick();
      vectors++;
      if ({o_Busy, o_Level, o_Overrun} !== {1'b0, 4'd0, 1'b0}) begin
         miscompares++;
         $display("FAIL loop_drain: got busy=%b lvl=%0d ovr=%b want 0 0 0", o_Busy, o_Level, o_Overrun);
      end
`ifdef UART_ECHO_STATS_EN
      vectors++;
      if ({o_Rx_Count, o_Tx_Count} !== {16'd8, 16'd8}) begin
         miscompares++;
         $display("FAIL loop_counts: got rx=%0d tx=%0d want 8 8", o_Rx_Count, o_Tx_Count);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_single_echo();
      test_xor_order();
      test_overrun();
      test_full_push_pop();
      test_reset_mid_send();
      test_loopback();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_echo_responder.md
# uart_echo_responder

Far-end responder for the UART link. It consumes byte strobes from a UART receiver, buffers them in a small FIFO and replays each byte, optionally XOR-transformed, through a UART transmitter. It sits between the RX and TX halves of `uart_controller` on the device side, so a host-side initiator can run byte-for-byte loopback checks against real silicon.

## Interface
Parameters:
- `DEPTH`, 8: FIFO depth in bytes; must be a power of two, at least 2.
- `ECHO_XOR`, 8'h00: mask XORed into every echoed byte.
- `GAP_CYCLES`, 0: idle clocks inserted after each `i_Tx_Done` before the next start. Width 16.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `i_Rx_Done`  in  1  one-cycle strobe; `i_Rx_Byte` is valid in that cycle.
- `i_Rx_Byte`  in  8  received byte.
- `i_Tx_Done`  in  1  one-cycle strobe; the transmitter finished the current byte.
- `o_Tx_Ready`  out  1  one-cycle start pulse to the transmitter.
- `o_Tx_Byte`  out  8  byte to send; held stable from the start pulse until `i_Tx_Done`.
- `o_Busy`  out  1  high in any state other than IDLE.
- `o_Level`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `o_Overrun`  out  1  sticky flag: a byte was dropped because the FIFO was full.
- `i_Clr_Overrun`  in  1  clears `o_Overrun`.

## Operation
- FIFO:
  - Circular buffer; pointers are $clog2(DEPTH) bits and wrap naturally.
  - Occupancy counter is one bit wider than the pointers.
  - Push on `i_Rx_Done` when not full, or when full and a pop happens in the same cycle.
  - Push while full with no pop drops the byte, sets `o_Overrun` and leaves the FIFO unchanged.
- Overrun clear: `i_Clr_Overrun` clears the flag. If it coincides with a new drop, the set wins.
- FSM states:
  - IDLE: if the FIFO is not empty, pop the head, load `o_Tx_Byte = head ^ ECHO_XOR`, pulse `o_Tx_Ready`, go to SEND.
  - SEND: wait for `i_Tx_Done`. On `i_Tx_Done`, go to GAP if `GAP_CYCLES != 0`, otherwise go to IDLE.
  - GAP: a down-counter is loaded with `GAP_CYCLES`. When it reaches 0, go to IDLE.
- `i_Tx_Done` received in IDLE or GAP is ignored. This covers stray strobes after a reset.
- Push and pop in the same cycle leave `o_Level` unchanged, including at empty+1 and at full.

## Timing
- Reset values: `o_Tx_Ready=0`, `o_Tx_Byte=8'h00`, `o_Busy=0`, `o_Level=0`, `o_Overrun=0`; FSM in IDLE; pointers and gap counter at 0.
- Reset mid-operation: the in-flight byte and all buffered bytes are discarded and no further `o_Tx_Ready` is issued. Reset has priority over every input.
- Latency, idle and empty case: `i_Rx_Done` in cycle N gives `o_Level=1` in N+1, and `o_Tx_Ready=1` with a valid `o_Tx_Byte` in N+2.
- `o_Tx_Ready` is exactly one cycle wide.
- Back-to-back, no gap: `i_Tx_Done` in cycle M with a non-empty FIFO gives the next `o_Tx_Ready` in M+2.
- Back-to-back, with gap: the next `o_Tx_Ready` comes in M+2+`GAP_CYCLES`.
- `o_Level` and `o_Overrun` are registered and update one cycle after the causing event.

## Configuration
- Macro `UART_ECHO_STATS_EN`.
- Defined: adds two outputs.
  - `o_Rx_Count [15:0]` counts accepted pushes; dropped bytes are excluded.
  - `o_Tx_Count [15:0]` counts `o_Tx_Ready` pulses.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters do not exist. All other behaviour is identical.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state encoding (IDLE/SEND/GAP, 2 bits);
  - `UART_BYTE_W = 8`;
  - the saturating counter width `UART_STAT_W = 16`.
- One sub-module, `uart_byte_fifo`: parameterised by `DEPTH`, with push, pop, full, empty and level.
- FSM, gap counter, overrun logic and stats live in the top level.

## Test plan
- Reset, then a single `i_Rx_Done` with 8'h55 (`ECHO_XOR=0`) -> `o_Tx_Ready` pulses 2 cycles later with `o_Tx_Byte=8'h55`; `o_Busy` stays high until `i_Tx_Done`.
- `ECHO_XOR=8'hFF`, push 8'h01, 8'h10, 8'hAA -> transmitted in order as 8'hFE, 8'hEF, 8'h55; `o_Level` peaks at 2 while the first byte is in flight.
- `DEPTH=8`, hold `i_Tx_Done` low and push 10 bytes -> the first byte is popped into SEND, 8 are buffered (`o_Level=8`), the 10th sets `o_Overrun`; `i_Clr_Overrun` then clears it.
- Full FIFO, with push and pop in the same cycle -> the push is accepted, `o_Level` stays at 8, no overrun.
- `GAP_CYCLES=5`, two queued bytes, `i_Tx_Done` at cycle M -> second `o_Tx_Ready` at M+7. Assert reset mid-SEND -> all outputs return to reset values and a later `i_Tx_Done` produces no pulse.
- Loopback with `uart_controller` (25 MHz, 115200 baud, 217 clocks/bit): host sends 8'h21, 8'h11, 8'h32, 8'h77, 8'hA0, 8'h0B, 8'hBB, 8'hFF -> identical bytes return in order. With `UART_ECHO_STATS_EN`, both counters read 8.
